clock_set_ctrl: RTL

Time-setting controller for the digital clock. Debounces two push-buttons (mode, increment) and runs a field-select FSM (hour, min, sec). While a field is being edited it pauses the time counter and drives blink masks to the segment driver. On exit it issues a one-cycle parallel load of the edited time into the counter.

---
 rtl/clock_set_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-setting controller for the digital clock.
// Debounces the mode/inc keys and walks a field-select FSM (RUN -> hour -> min -> sec).
// While editing it freezes the counter and blinks the edited field.
// Leaving the seconds field pulses a one-cycle parallel load of the edited time.
// Optional macro AUTO_REPEAT_EN: holding inc in an edit state generates repeated increments.
module clock_set_ctrl #(
    parameter int DB_CYCLES     = 1000000,
    parameter int BLINK_HALF    = 12500000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic       run_en,
    output logic       load,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic [2:0] blink_mask
);
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int BW  = $clog2(BLINK_HALF + 1);

    typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;

    if (DB_CYCLES < 1 || BLINK_HALF < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_chk
        $error("clock_set_ctrl: all cycle parameters must be at least 1");
    end

    state_t         state, state_nx;
    logic [1:0]     raw, s1, s2, stable, stable_d, press;
    logic [DBW-1:0] db_cnt [2];
    logic           mode_ev, inc_ev, inc_act;
    logic [4:0]     edit_hour;
    logic [5:0]     edit_min, edit_sec;
    logic [BW-1:0]  blink_cnt;
    logic           blink_off;

    // bit 0 is the mode key, bit 1 the inc key; both are active-low
    assign raw     = {key_inc, key_mode};
    assign press   = stable_d & ~stable;
    assign mode_ev = press[0];

    // two-flop synchroniser plus debounce: a level is accepted after DB_CYCLES of disagreement
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1       <= 2'b11;
            s2       <= 2'b11;
            stable   <= 2'b11;
            stable_d <= 2'b11;
            for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
        end else begin
            s1       <= raw;
            s2       <= s1;
            stable_d <= stable;
            for (int k = 0; k < 2; k++) begin
                if (s2[k] == stable[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DBW'(DB_CYCLES - 1)) begin
                    stable[k] <= s2[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_arm, rep_on, rep_ev;

    // first synthetic event after HOLD_CYCLES, then one every REPEAT_CYCLES
    assign rep_ev = rep_arm && !stable[1] &&
                    rep_cnt == (rep_on ? RW'(REPEAT_CYCLES - 1) : RW'(HOLD_CYCLES - 1));
    assign inc_ev = press[1] | rep_ev;

    // hold/repeat timer, armed by an accepted inc press and dropped on release or state change
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rep_cnt <= '0;
            rep_arm <= 1'b0;
            rep_on  <= 1'b0;
        end else if (stable[1] || mode_ev || state == RUN) begin
            rep_cnt <= '0;
            rep_arm <= 1'b0;
            rep_on  <= 1'b0;
        end else if (press[1]) begin
            rep_cnt <= '0;
            rep_arm <= 1'b1;
            rep_on  <= 1'b0;
        end else if (rep_ev) begin
            rep_cnt <= '0;
            rep_on  <= 1'b1;
        end else if (rep_arm) begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end
`else
    assign inc_ev = press[1];
`endif

    // mode has priority: an inc arriving with a mode event is dropped
    assign inc_act = inc_ev & ~mode_ev;

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= RUN;
        else       state <= state_nx;
    end

    // next state: each mode event advances one field, seconds wraps back to RUN
    always_comb begin
        state_nx = !mode_ev           ? state    :
                   state == RUN       ? SET_HOUR :
                   state == SET_HOUR  ? SET_MIN  :
                   state == SET_MIN   ? SET_SEC  : RUN;
    end

    // outputs: counter runs only in RUN, the edited field blanks during the off phase
    always_comb begin
        run_en     = state == RUN;
        blink_mask = !blink_off          ? 3'b000 :
                     state == SET_HOUR   ? 3'b100 :
                     state == SET_MIN    ? 3'b010 :
                     state == SET_SEC    ? 3'b001 : 3'b000;
    end

    // edit registers: capture live time on entry (out-of-range -> 0), wrap each field on inc
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            edit_hour <= '0;
            edit_min  <= '0;
            edit_sec  <= '0;
        end else if (state == RUN) begin
            if (mode_ev) begin
                edit_hour <= (cur_hour > 5'd23) ? 5'd0 : cur_hour;
                edit_min  <= (cur_min > 6'd59) ? 6'd0 : cur_min;
                edit_sec  <= (cur_sec > 6'd59) ? 6'd0 : cur_sec;
            end
        end else if (inc_act) begin
            if (state == SET_HOUR) edit_hour <= (edit_hour == 5'd23) ? 5'd0 : edit_hour + 5'd1;
            if (state == SET_MIN)  edit_min  <= (edit_min == 6'd59) ? 6'd0 : edit_min + 6'd1;
            if (state == SET_SEC)  edit_sec  <= (edit_sec == 6'd59) ? 6'd0 : edit_sec + 6'd1;
        end
    end

    // load pulse and load values, registered on the edge that leaves SET_SEC
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load     <= 1'b0;
            set_hour <= '0;
            set_min  <= '0;
            set_sec  <= '0;
        end else begin
            load <= state == SET_SEC && mode_ev;
            if (state == SET_SEC && mode_ev) begin
                set_hour <= edit_hour;
                set_min  <= edit_min;
                set_sec  <= edit_sec;
            end
        end
    end

    // blink phase: restarts "on" at every state entry and on every accepted increment
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (state_nx != state || state == RUN || inc_act) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
endmodule
